// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU ops plus a multi-cycle restoring divider
// that owns the HI/LO pair and holds the front of the pipeline while it runs.
module ex_stage #(
    parameter int unsigned DW   = 32,
    parameter int unsigned OPW  = 8,
    parameter int unsigned SELW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [31:0]     pc_i,
    input  logic [OPW-1:0]  aluop_i,
    input  logic [SELW-1:0] alusel_i,
    input  logic [DW-1:0]   rdata1_i,
    input  logic [DW-1:0]   rdata2_i,
    input  logic [4:0]      rw_i,
    input  logic            wreg_i,
    output logic [31:0]     pc_o,
    output logic [4:0]      rw_o,
    output logic            wreg_o,
    output logic [DW-1:0]   wdata_o,
    output logic [DW-1:0]   hi_o,
    output logic [DW-1:0]   lo_o,
    output logic            stallreq
);

    localparam int unsigned SHW = $clog2(DW);
    localparam int unsigned CW  = $clog2(DW);

    localparam logic [OPW-1:0] OP_NOP  = OPW'(8'h00);
    localparam logic [OPW-1:0] OP_AND  = OPW'(8'h24);
    localparam logic [OPW-1:0] OP_OR   = OPW'(8'h25);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(8'h26);
    localparam logic [OPW-1:0] OP_NOR  = OPW'(8'h27);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(8'h7C);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(8'h02);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(8'h03);
    localparam logic [OPW-1:0] OP_ADDU = OPW'(8'h21);
    localparam logic [OPW-1:0] OP_SUBU = OPW'(8'h23);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(8'h2A);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(8'h2B);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(8'h1A);
    localparam logic [OPW-1:0] OP_DIVU = OPW'(8'h1B);
    localparam logic [OPW-1:0] OP_MFHI = OPW'(8'h10);
    localparam logic [OPW-1:0] OP_MFLO = OPW'(8'h12);

    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] quo;
    logic [DW:0]   rem;
    logic [DW-1:0] dvsr;
    logic          q_neg;
    logic          r_neg;

    logic          is_div;
    logic          a_neg;
    logic          b_neg;
    logic [DW-1:0] abs_a;
    logic [DW-1:0] abs_b;
    logic [DW:0]   rem_sh;
    logic          trial_ok;
    logic [SHW-1:0] shamt;

    // Result class is decided upstream and not needed here.
    logic unused_sel;
    assign unused_sel = ^alusel_i;

    assign pc_o   = pc_i;
    assign rw_o   = rw_i;
    assign wreg_o = wreg_i & ~stallreq & ~flush;
    assign shamt  = rdata1_i[SHW-1:0];

    // Operand conditioning for the divider: magnitudes for DIV, raw for DIVU.
    assign is_div = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign a_neg  = (aluop_i == OP_DIV) && rdata1_i[DW-1];
    assign b_neg  = (aluop_i == OP_DIV) && rdata2_i[DW-1];
    assign abs_a  = a_neg ? -rdata1_i : rdata1_i;
    assign abs_b  = b_neg ? -rdata2_i : rdata2_i;

    // One restoring step: shift in next dividend bit, trial subtract.
    assign rem_sh   = {rem[DW-1:0], quo[DW-1]};
    assign trial_ok = rem_sh >= {1'b0, dvsr};

    // Hold the front of the pipe on divide entry and while iterating.
    always_comb begin
        stallreq = 1'b0;
        if (!rst && !flush) begin
            if (state == S_RUN)
                stallreq = 1'b1;
            else if (state == S_IDLE && is_div)
                stallreq = 1'b1;
        end
    end

    // Single-cycle result mux; divides and unknown codes read as zero.
    always_comb begin
        wdata_o = '0;
        case (aluop_i)
            OP_AND:  wdata_o = rdata1_i & rdata2_i;
            OP_OR:   wdata_o = rdata1_i | rdata2_i;
            OP_XOR:  wdata_o = rdata1_i ^ rdata2_i;
            OP_NOR:  wdata_o = ~(rdata1_i | rdata2_i);
            OP_SLL:  wdata_o = rdata2_i << shamt;
            OP_SRL:  wdata_o = rdata2_i >> shamt;
            OP_SRA:  wdata_o = DW'($signed(rdata2_i) >>> shamt);
            OP_ADDU: wdata_o = rdata1_i + rdata2_i;
            OP_SUBU: wdata_o = rdata1_i - rdata2_i;
            OP_SLT:  wdata_o = DW'($signed(rdata1_i) < $signed(rdata2_i));
            OP_SLTU: wdata_o = DW'(rdata1_i < rdata2_i);
            OP_MFHI: wdata_o = hi_o;
            OP_MFLO: wdata_o = lo_o;
            OP_NOP, OP_DIV, OP_DIVU: wdata_o = '0;
            default: wdata_o = '0;
        endcase
    end

    // Divider FSM and HI/LO ownership; flush aborts without touching HI/LO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvsr  <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            hi_o  <= '0;
            lo_o  <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_div) begin
                        cnt <= '0;
                        if (rdata2_i == '0) begin
                            // Divide by zero: fixed result, no sign fix-up.
                            quo   <= '1;
                            rem   <= {1'b0, rdata1_i};
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            quo   <= abs_a;
                            rem   <= '0;
                            dvsr  <= abs_b;
                            q_neg <= a_neg ^ b_neg;
                            r_neg <= a_neg;
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    quo <= {quo[DW-2:0], trial_ok};
                    rem <= trial_ok ? (rem_sh - {1'b0, dvsr}) : rem_sh;
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST)
                        state <= S_DONE;
                end
                S_DONE: begin
                    lo_o  <= q_neg ? -quo : quo;
                    hi_o  <= r_neg ? -rem[DW-1:0] : rem[DW-1:0];
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
